// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage access controller: funct3 codes,
// control-bit positions, FSM state encoding and an access-size helper.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] F3_SB = 2'b00;
  localparam logic [1:0] F3_SH = 2'b01;
  localparam logic [1:0] F3_SW = 2'b10;

  localparam int LOAD_EN_BIT  = 3;
  localparam int STORE_EN_BIT = 2;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD
  } access_size_e;

  // Loads and stores share funct3[1:0] as the size field.
  function automatic access_size_e sizeOf(input logic [2:0] funct3);
    case (funct3[1:0])
      F3_SB:   sizeOf = SIZE_BYTE;
      F3_SH:   sizeOf = SIZE_HALF;
      default: sizeOf = SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data-memory port; master is the access unit,
// slave is the memory.
interface mem_access_unit_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [29:0] dmem_addr;
  logic [3:0]  dmem_byte_en;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_byte_en, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_byte_en, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_access_unit_load_store_aligner.sv
// Combinational lane logic: byte enables, store-data replication,
// load-lane extraction with sign/zero extension, and misalignment detect.
module load_store_aligner
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  access_size_e size;
  logic [31:0]  lane;
  logic         isUnsigned;

  assign size       = sizeOf(funct3_i);
  assign lane       = rdata_i >> {addr_lo_i, 3'b000};
  assign isUnsigned = (funct3_i == F3_LBU) || (funct3_i == F3_LHU);

  always_comb begin
    byte_en_o    = 4'b1111;
    wdata_o      = store_data_i;
    load_data_o  = rdata_i;
    misaligned_o = 1'b0;
    case (size)
      SIZE_BYTE: begin
        byte_en_o   = 4'b0001 << addr_lo_i;
        wdata_o     = {4{store_data_i[7:0]}};
        load_data_o = isUnsigned ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      end
      SIZE_HALF: begin
        byte_en_o    = 4'b0011 << addr_lo_i;
        wdata_o      = {2{store_data_i[15:0]}};
        load_data_o  = isUnsigned ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
        misaligned_o = addr_lo_i[0];
      end
      default: begin
        misaligned_o = |addr_lo_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: IDLE/WAIT/DONE handshake FSM,
// pipeline stall generation and the registered load result.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               mem_alu_out_i,
  input  logic [31:0]               mem_reg_data2_i,
  input  logic [3:0]                mem_data_mem_read_i,
  input  logic [2:0]                mem_data_mem_write_i,
  mem_access_unit_if.master         dmem,
  output logic [31:0]               load_data_o,
  output logic                      stall_o,
  output logic                      misaligned_o
);

  state_t      state_q, state_d;
  logic [31:0] load_data_q, load_data_d;

  logic        loadEn, storeEn, accessReq, accessValid, busy;
  logic [2:0]  funct3;
  logic [31:0] alignedLoad;
  logic        misalignedRaw;

  // A load wins when both enables are set, so its funct3 selects the size.
  assign loadEn    = mem_data_mem_read_i[LOAD_EN_BIT];
  assign storeEn   = mem_data_mem_write_i[STORE_EN_BIT];
  assign accessReq = loadEn || storeEn;
  assign funct3    = loadEn ? mem_data_mem_read_i[2:0] : {1'b0, mem_data_mem_write_i[1:0]};

  load_store_aligner u_aligner (
    .funct3_i     (funct3),
    .addr_lo_i    (mem_alu_out_i[1:0]),
    .store_data_i (mem_reg_data2_i),
    .rdata_i      (dmem.dmem_rdata),
    .byte_en_o    (dmem.dmem_byte_en),
    .wdata_o      (dmem.dmem_wdata),
    .load_data_o  (alignedLoad),
    .misaligned_o (misalignedRaw)
  );

  assign misaligned_o = accessReq && misalignedRaw;
  assign accessValid  = accessReq && !misalignedRaw;
  assign busy         = accessValid && (state_q != ST_DONE);

  // Request and stall are gated by reset so they fall asynchronously.
  assign stall_o        = busy && !rst;
  assign dmem.dmem_req  = stall_o;
  assign dmem.dmem_we   = stall_o && !loadEn;
  assign dmem.dmem_addr = mem_alu_out_i[31:2];
  assign load_data_o    = load_data_q;

  always_comb begin
    state_d     = state_q;
    load_data_d = load_data_q;
    case (state_q)
      ST_IDLE: if (accessValid) state_d = dmem.dmem_ack ? ST_DONE : ST_WAIT;
      ST_WAIT: if (dmem.dmem_ack) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (busy && dmem.dmem_ack && loadEn) load_data_d = alignedLoad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      load_data_q <= load_data_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit against an
// arithmetic reference model of lane selection and handshake timing.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic [31:0] aluOut;
  logic [31:0] regData2;
  logic [3:0]  memRead;
  logic [2:0]  memWrite;
  logic [31:0] loadData;
  logic        stall;
  logic        misaligned;

  int checks = 0;
  int errors = 0;
  logic [31:0] expLoad = 32'h0;

  mem_access_unit_if bus();

  mem_access_unit dut (
    .clk                  (clk),
    .rst                  (rst),
    .mem_alu_out_i        (aluOut),
    .mem_reg_data2_i      (regData2),
    .mem_data_mem_read_i  (memRead),
    .mem_data_mem_write_i (memWrite),
    .dmem                 (bus),
    .load_data_o          (loadData),
    .stall_o              (stall),
    .misaligned_o         (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: pick the addressed byte/half numerically, then extend.
  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] word);
    logic [31:0] lane;
    longint v;
    lane = word >> (8 * off);
    case (f3[1:0])
      2'b00: begin
        v = longint'(lane % 256);
        if (!f3[2] && v >= 128) v = v - 256;
      end
      2'b01: begin
        v = longint'(lane % 65536);
        if (!f3[2] && v >= 32768) v = v - 65536;
      end
      default: v = longint'(word);
    endcase
    return v[31:0];
  endfunction

  function automatic int sizeBytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  task automatic setIdle();
    memRead  = 4'b0;
    memWrite = 3'b0;
    aluOut   = $urandom;
    regData2 = $urandom;
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase.
  task automatic applyStimulus(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                               input logic [31:0] rs2, input logic [31:0] rdata, input int lat,
                               input string name);
    logic        isLoad, isStore, mis;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    int          sz, stallCount;
    memRead  = rd;
    memWrite = wr;
    aluOut   = addr;
    regData2 = rs2;
    isLoad   = rd[3];
    isStore  = wr[2] && !isLoad;
    f3       = isLoad ? rd[2:0] : {1'b0, wr[1:0]};
    sz       = sizeBytes(f3);
    off      = addr[1:0];
    mis      = (addr % sz) != 0;
    expBe    = (sz == 4) ? 4'hF : 4'((2 ** sz - 1) << off);
    expWdata = (sz == 1) ? rs2[7:0] * 32'h01010101 :
               (sz == 2) ? rs2[15:0] * 32'h00010001 : rs2;
    if (mis) begin
      @(negedge clk);
      checkOutput({name, " misaligned"}, {31'b0, misaligned}, 32'h1);
      checkOutput({name, " mis req"}, {31'b0, bus.dmem_req}, 32'h0);
      checkOutput({name, " mis stall"}, {31'b0, stall}, 32'h0);
      @(posedge clk); #1;
      checkOutput({name, " mis load_data"}, loadData, expLoad);
      setIdle();
      return;
    end
    stallCount = 0;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checkOutput({name, " misaligned"}, {31'b0, misaligned}, 32'h0);
        checkOutput({name, " we"}, {31'b0, bus.dmem_we}, {31'b0, isStore});
        checkOutput({name, " byte_en"}, {28'b0, bus.dmem_byte_en}, {28'b0, expBe});
        checkOutput({name, " addr"}, {2'b0, bus.dmem_addr}, addr >> 2);
        if (isStore) checkOutput({name, " wdata"}, bus.dmem_wdata, expWdata);
      end
      checkOutput({name, " req"}, {31'b0, bus.dmem_req}, 32'h1);
      if (stall) stallCount++;
      if (k == lat) begin
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rdata;
      end
      @(posedge clk); #1;
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = $urandom;
    end
    if (isLoad) expLoad = modelLoad(f3, off, rdata);
    @(negedge clk);
    checkOutput({name, " done req"}, {31'b0, bus.dmem_req}, 32'h0);
    checkOutput({name, " done stall"}, {31'b0, stall}, 32'h0);
    checkOutput({name, " stall cycles"}, 32'(stallCount), 32'(lat + 1));
    checkOutput({name, " load_data"}, loadData, expLoad);
    @(posedge clk); #1;
    setIdle();
  endtask

  logic [2:0] loadF3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [3:0] rRd;
  logic [2:0] rWr;
  int         kind;

  initial begin
    rst            = 1'b1;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    memRead        = 4'b0;
    memWrite       = 3'b110;
    aluOut         = 32'h0000_0010;
    regData2       = 32'h5555_AAAA;
    #3;
    checkOutput("reset req", {31'b0, bus.dmem_req}, 32'h0);
    checkOutput("reset we", {31'b0, bus.dmem_we}, 32'h0);
    checkOutput("reset stall", {31'b0, stall}, 32'h0);
    checkOutput("reset load_data", loadData, 32'h0);
    setIdle();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(4'b1010, 3'b000, 32'h100, 32'h0, 32'hDEADBEEF, 0, "lw0");
    applyStimulus(4'b1000, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, "lb");
    applyStimulus(4'b1100, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, "lbu");
    applyStimulus(4'b0000, 3'b101, 32'h202, 32'h1234ABCD, 32'h0, 3, "sh");
    applyStimulus(4'b1010, 3'b000, 32'h102, 32'h0, 32'h0, 0, "lwmis");
    applyStimulus(4'b1001, 3'b110, 32'h0FE, 32'h0, 32'h8001_7FFF, 2, "both");

    // Reset while a load is waiting for its acknowledge.
    memRead = 4'b1000;
    aluOut  = 32'h101;
    @(negedge clk);
    checkOutput("rstwait req0", {31'b0, bus.dmem_req}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rstwait stall", {31'b0, stall}, 32'h1);
    #1 rst = 1'b1;
    expLoad = 32'h0;
    #1;
    checkOutput("rstwait req drop", {31'b0, bus.dmem_req}, 32'h0);
    checkOutput("rstwait stall drop", {31'b0, stall}, 32'h0);
    checkOutput("rstwait load_data", loadData, expLoad);
    setIdle();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    checkOutput("stray ack load_data", loadData, expLoad);
    checkOutput("stray ack req", {31'b0, bus.dmem_req}, 32'h0);
    @(posedge clk); #1;

    applyStimulus(4'b0000, 3'b110, 32'h008, 32'h11223344, 32'h0, 0, "b2b sw");
    applyStimulus(4'b1101, 3'b000, 32'h006, 32'h0, 32'hF00D0000, 0, "b2b lhu");

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        rRd = {1'b1, loadF3[$urandom_range(0, 4)]};
        rWr = (kind == 4) ? {1'b1, 2'($urandom_range(0, 2))} : 3'b000;
      end else begin
        rRd = {1'b0, 3'($urandom)};
        rWr = {1'b1, 2'($urandom_range(0, 2))};
      end
      applyStimulus(rRd, rWr, $urandom, $urandom, $urandom, $urandom_range(0, 3), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
